// File: rtl/digdug_intctl.sv
// Dig Dug reset/interrupt sequencer: control latches, power-up reset sequence, vblank IRQs, sound NMI.
// Define DIGDUG_INTCTL_WATCHDOG_EN to add the vblank watchdog kicked by writes to 0x6830.
module digdug_intctl #(
  parameter int unsigned VBL_LINE  = 224,
  parameter int unsigned NMI_LINE0 = 64,
  parameter int unsigned NMI_LINE1 = 192,
  parameter int unsigned NMI_W     = 64,
  parameter int unsigned RST_HOLD  = 4096
) (
  input  logic        MCLK,
  input  logic        RESET,
  input  logic        WR_STB,
  input  logic [15:0] WR_AD,
  input  logic [7:0]  WR_DT,
  input  logic        LINE_STB,
  input  logic [8:0]  VPOS,
  input  logic        NMI0_REQ,
  output logic [2:0]  RSTS,
  output logic [2:0]  IRQS,
  output logic [2:0]  NMIS
);

  localparam logic [8:0]  VblLine  = 9'(VBL_LINE);
  localparam logic [8:0]  NmiLine0 = 9'(NMI_LINE0);
  localparam logic [8:0]  NmiLine1 = 9'(NMI_LINE1);
  localparam logic [7:0]  NmiWidth = 8'(NMI_W);
  localparam logic [15:0] HoldLast = 16'(RST_HOLD - 1);

  typedef enum logic [1:0] {StRst, StHold, StRun} state_e;

  state_e      state_q, state_d;
  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic        ien0_q, ien0_d;
  logic        ien1_q, ien1_d;
  logic        ndis2_q, ndis2_d;
  logic        subrun_q, subrun_d;
  logic        pend0_q, pend0_d;
  logic        pend1_q, pend1_d;
  logic [7:0]  nmi_cnt_q, nmi_cnt_d;
  logic [2:0]  rsts_q, rsts_d;

  logic running, run_d, wr_en, vbl_evt, nmi_evt, bite;
  logic wr_ien0, wr_ien1, wr_ndis2, wr_subrun;

`ifdef DIGDUG_INTCTL_WATCHDOG_EN
  logic [4:0] wd_q, wd_d;
  logic       kick;
`endif

  logic unused_dt;
  assign unused_dt = ^WR_DT[7:1];

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    ien0_d     = ien0_q;
    ien1_d     = ien1_q;
    ndis2_d    = ndis2_q;
    subrun_d   = subrun_q;
    pend0_d    = pend0_q;
    pend1_d    = pend1_q;
    nmi_cnt_d  = nmi_cnt_q;
    bite       = 1'b0;

    running   = (state_q == StRun);
    wr_en     = WR_STB & running;
    wr_ien0   = wr_en & (WR_AD == 16'h6820);
    wr_ien1   = wr_en & (WR_AD == 16'h6821);
    wr_ndis2  = wr_en & (WR_AD == 16'h6822);
    wr_subrun = wr_en & (WR_AD == 16'h6823);
    vbl_evt   = LINE_STB & (VPOS == VblLine);
    nmi_evt   = LINE_STB & ((VPOS == NmiLine0) | (VPOS == NmiLine1));

    // The count starts on the first edge out of StRst, so RUN arrives on edge RST_HOLD.
    unique case (state_q)
      StRst, StHold: begin
        if (hold_cnt_q == HoldLast) begin
          state_d = StRun;
        end else begin
          state_d    = StHold;
          hold_cnt_d = hold_cnt_q + 16'd1;
        end
      end
      StRun:   state_d = StRun;
      default: state_d = StRst;
    endcase

    if (wr_ien0)   ien0_d   = WR_DT[0];
    if (wr_ien1)   ien1_d   = WR_DT[0];
    if (wr_ndis2)  ndis2_d  = WR_DT[0];
    if (wr_subrun) subrun_d = WR_DT[0];

`ifdef DIGDUG_INTCTL_WATCHDOG_EN
    wd_d = wd_q;
    kick = WR_STB & (WR_AD == 16'h6830);
    if (kick) begin
      wd_d = 5'd0;
    end else if (running && vbl_evt) begin
      wd_d = wd_q + 5'd1;
      if (wd_d == 5'd16) begin
        bite = 1'b1;
        wd_d = 5'd0;
      end
    end
`endif

    if (bite) begin
      state_d    = StHold;
      hold_cnt_d = 16'd0;
      ien0_d     = 1'b0;
      ien1_d     = 1'b0;
      ndis2_d    = 1'b1;
      subrun_d   = 1'b0;
    end

    run_d  = (state_d == StRun);
    rsts_d = {{2{~run_d | ~subrun_d}}, ~run_d};

    // Forcing uses next-cycle reset levels so a CPU never sees IRQ/NMI while held in reset.
    // Set conditions use the pre-write enables; a clearing write beats a set.
    if (!run_d) begin
      pend0_d = 1'b0;
    end else if (wr_ien0 && !WR_DT[0]) begin
      pend0_d = 1'b0;
    end else if (vbl_evt && ien0_q) begin
      pend0_d = 1'b1;
    end

    if (rsts_d[1]) begin
      pend1_d = 1'b0;
    end else if (wr_ien1 && !WR_DT[0]) begin
      pend1_d = 1'b0;
    end else if (vbl_evt && ien1_q) begin
      pend1_d = 1'b1;
    end

    if (rsts_d[2]) begin
      nmi_cnt_d = 8'd0;
    end else if (nmi_evt && !ndis2_q) begin
      nmi_cnt_d = NmiWidth;
    end else if (nmi_cnt_q != 8'd0) begin
      nmi_cnt_d = nmi_cnt_q - 8'd1;
    end
  end

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= StRst;
      hold_cnt_q <= 16'd0;
      ien0_q     <= 1'b0;
      ien1_q     <= 1'b0;
      ndis2_q    <= 1'b1;
      subrun_q   <= 1'b0;
      pend0_q    <= 1'b0;
      pend1_q    <= 1'b0;
      nmi_cnt_q  <= 8'd0;
      rsts_q     <= 3'b111;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      ien0_q     <= ien0_d;
      ien1_q     <= ien1_d;
      ndis2_q    <= ndis2_d;
      subrun_q   <= subrun_d;
      pend0_q    <= pend0_d;
      pend1_q    <= pend1_d;
      nmi_cnt_q  <= nmi_cnt_d;
      rsts_q     <= rsts_d;
    end
  end

`ifdef DIGDUG_INTCTL_WATCHDOG_EN
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      wd_q <= 5'd0;
    end else begin
      wd_q <= wd_d;
    end
  end
`endif

  assign RSTS = rsts_q;
  assign IRQS = {1'b0, pend1_q, pend0_q};
  assign NMIS = {(nmi_cnt_q != 8'd0), 1'b0, NMI0_REQ & running};

endmodule

// File: tb/tb_digdug_intctl.sv
// Scoreboard bench for digdug_intctl: the driver pushes per-cycle expectations from a
// cycle-count based reference model; a negedge monitor pops and compares all outputs.
module tb_digdug_intctl;

  localparam int VBL  = 224;
  localparam int N0   = 64;
  localparam int N1   = 192;
  localparam int NW   = 64;
  localparam int HOLD = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_stb = 1'b0;
  logic [15:0] wr_ad = 16'h0;
  logic [7:0]  wr_dt = 8'h0;
  logic        line_stb = 1'b0;
  logic [8:0]  vpos = 9'h0;
  logic        nmi0_req = 1'b0;
  logic [2:0]  rsts, irqs, nmis;

  always #5 clk = ~clk;

  digdug_intctl dut (
    .MCLK    (clk),
    .RESET   (rst),
    .WR_STB  (wr_stb),
    .WR_AD   (wr_ad),
    .WR_DT   (wr_dt),
    .LINE_STB(line_stb),
    .VPOS    (vpos),
    .NMI0_REQ(nmi0_req),
    .RSTS    (rsts),
    .IRQS    (irqs),
    .NMIS    (nmis)
  );

  // Reference model: CPUs run once HOLD edges have elapsed since reset release (or watchdog bite);
  // the NMI is high while the edge count is below the recorded end time.
  int m_edges, cyc, nmi_end, wd;
  bit m_ien0, m_ien1, m_ndis2, m_subrun, m_p0, m_p1;

  logic [8:0] exp_q[$];
  int checks = 0;
  int passes = 0;

  task automatic model_reset();
    m_edges = 0; nmi_end = 0; wd = 0;
    m_ien0 = 0; m_ien1 = 0; m_ndis2 = 1; m_subrun = 0; m_p0 = 0; m_p1 = 0;
  endtask

  task automatic model_step();
    bit old_run, vbl, trig, bite, run, sub_rst, o_ien0, o_ien1, o_ndis2, w;
    old_run = (m_edges >= HOLD);
    cyc++;
    w    = wr_stb && old_run;
    vbl  = line_stb && (vpos == VBL);
    trig = line_stb && (vpos == N0 || vpos == N1);
    o_ien0 = m_ien0; o_ien1 = m_ien1; o_ndis2 = m_ndis2;
    if (w) begin
      case (wr_ad)
        16'h6820: m_ien0   = wr_dt[0];
        16'h6821: m_ien1   = wr_dt[0];
        16'h6822: m_ndis2  = wr_dt[0];
        16'h6823: m_subrun = wr_dt[0];
        default: ;
      endcase
    end
    if (m_edges < HOLD) m_edges++;
    bite = 0;
`ifdef DIGDUG_INTCTL_WATCHDOG_EN
    if (wr_stb && wr_ad == 16'h6830) wd = 0;
    else if (old_run && vbl) begin
      wd++;
      if (wd == 16) begin
        bite = 1;
        wd = 0;
      end
    end
`endif
    if (bite) begin
      m_edges = 0; m_ien0 = 0; m_ien1 = 0; m_ndis2 = 1; m_subrun = 0;
    end
    run     = (m_edges >= HOLD);
    sub_rst = !run || !m_subrun;
    if (!run) m_p0 = 0;
    else if (w && wr_ad == 16'h6820 && !wr_dt[0]) m_p0 = 0;
    else if (vbl && o_ien0) m_p0 = 1;
    if (sub_rst) m_p1 = 0;
    else if (w && wr_ad == 16'h6821 && !wr_dt[0]) m_p1 = 0;
    else if (vbl && o_ien1) m_p1 = 1;
    if (sub_rst) nmi_end = 0;
    else if (trig && !o_ndis2) nmi_end = cyc + NW;
  endtask

  function automatic logic [8:0] expected();
    bit run, sr;
    run = !rst && (m_edges >= HOLD);
    sr  = !run || !m_subrun;
    return {sr, sr, !run, 1'b0, m_p1, m_p0, (cyc < nmi_end), 1'b0, nmi0_req & run};
  endfunction

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s at %0t: got %b, required %b", name, $time, act, req);
  endtask

  always @(negedge clk) begin
    logic [8:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rsts", rsts, e[8:6]);
      check("irqs", irqs, e[5:3]);
      check("nmis", nmis, e[2:0]);
    end
  end

  task automatic drive(input logic n_rst, input logic n_wr, input logic [15:0] n_ad,
                       input logic [7:0] n_dt, input logic n_line, input logic [8:0] n_vpos);
    @(posedge clk);
    if (!rst) model_step();
    #1;
    rst = n_rst; wr_stb = n_wr; wr_ad = n_ad; wr_dt = n_dt;
    line_stb = n_line; vpos = n_vpos;
    nmi0_req = 1'($urandom_range(0, 1));
    if (n_rst) model_reset();
    exp_q.push_back(expected());
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 9'h0);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    drive(1'b0, 1'b1, a, d, 1'b0, 9'h0);
  endtask

  task automatic line(input int v);
    drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 9'(v));
  endtask

  task automatic rand_cycles(input int n);
    logic [15:0] addrs[8];
    logic [8:0]  lines[4];
    logic [15:0] a;
    logic [7:0]  d;
    logic        w, l;
    addrs = '{16'h6820, 16'h6821, 16'h6822, 16'h6823, 16'h6824, 16'h6827, 16'h6830, 16'h1234};
    lines = '{9'd64, 9'd192, 9'd224, 9'd0};
    for (int i = 0; i < n; i++) begin
      w = ($urandom_range(0, 9) < 3);
      l = ($urandom_range(0, 9) < 2);
      a = addrs[$urandom_range(0, 7)];
      if (a == 16'h1234) a = 16'($urandom);
      d = 8'($urandom);
      if (a == 16'h6823) d[0] = ($urandom_range(0, 3) != 0);
      lines[3] = 9'($urandom);
      drive(1'b0, w, a, d, l, lines[$urandom_range(0, 3)]);
    end
  endtask

  initial begin
    cyc = 0;
    #1 rst = 1'b1;
    model_reset();
    repeat (10) drive(1'b1, 1'b0, 16'h0, 8'h0, 1'b0, 9'h0);
    idle(HOLD + 4);
    wr(16'h6823, 8'h01); idle(3);
    // vblank IRQs and clear
    wr(16'h6820, 8'h01); wr(16'h6821, 8'h01); idle(2);
    line(224); idle(5);
    wr(16'h6820, 8'h00); idle(3);
    // sound NMI pulses, then disabled
    wr(16'h6822, 8'h00); line(64); idle(70); line(192); idle(70);
    wr(16'h6822, 8'h01); line(64); idle(70);
    // clearing write collides with vblank set
    wr(16'h6821, 8'h00); wr(16'h6821, 8'h01); idle(1);
    drive(1'b0, 1'b1, 16'h6821, 8'h00, 1'b1, 9'd224); idle(3);
    // write with same-cycle vblank uses the old (disabled) enable
    drive(1'b0, 1'b1, 16'h6820, 8'h01, 1'b1, 9'd224); idle(3);
    // sub-CPU reset during an NMI pulse
    wr(16'h6822, 8'h00); line(192); idle(10);
    wr(16'h6823, 8'h00); idle(5);
    wr(16'h6823, 8'h01); line(64); idle(5); line(64); idle(NW + 3);
`ifdef DIGDUG_INTCTL_WATCHDOG_EN
    wr(16'h6830, 8'h00);
    repeat (16) begin line(224); idle(1); end
    idle(HOLD + 4);
    wr(16'h6823, 8'h01); wr(16'h6830, 8'h00);
    repeat (3) begin
      repeat (15) begin line(224); idle(1); end
      wr(16'h6830, 8'h00);
    end
    idle(3);
`endif
    rand_cycles(3000);
    // asynchronous reset mid-operation restarts the hold count
    idle(2);
    drive(1'b1, 1'b0, 16'h0, 8'h0, 1'b0, 9'h0);
    repeat (2) drive(1'b1, 1'b0, 16'h0, 8'h0, 1'b0, 9'h0);
    idle(HOLD + 3);
    wr(16'h6823, 8'h01);
    rand_cycles(500);
    idle(2);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL drain: got %0d pending, required 0", exp_q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
